// File: rtl/id_stage.sv
// Decode/operand-fetch stage: 32x32 register file, field decode, immediate extension and a
// single-entry valid/ready output register. Optional write-through bypass: ID_WB_BYPASS_EN.
module id_stage #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       InsIn,
   input  logic [31:0]       nextPCIn,
   input  logic              InValid,
   output logic              InReady,
   input  logic              WE,
   input  logic [AW-1:0]     WAddr,
   input  logic [DATA_W-1:0] WData,
   output logic [31:0]       Ins,
   output logic [31:0]       nextPC,
   output logic [DATA_W-1:0] Rdata1,
   output logic [DATA_W-1:0] Rdata2,
   output logic [DATA_W-1:0] Ed32,
   output logic              OutValid,
   input  logic              OutReady
);

   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;

   logic [DATA_W-1:0] regs [NREG];
   logic [5:0]        opcode;
   logic [AW-1:0]     rs;
   logic [AW-1:0]     rt;
   logic [15:0]       imm;
   logic              capture;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] ext;

   // Logical immediates zero-extend, LUI shifts into the upper half, everything else sign-extends.
   function automatic logic [DATA_W-1:0] extend_imm(input logic [5:0] op, input logic [15:0] value);
      logic [DATA_W-1:0] result;
      case (op)
         OP_ANDI, OP_ORI, OP_XORI: result = {{(DATA_W-16){1'b0}}, value};
         OP_LUI:                   result = {{(DATA_W-32){1'b0}}, value, 16'h0000};
         default:                  result = {{(DATA_W-16){value[15]}}, value};
      endcase
      return result;
   endfunction

   assign opcode  = InsIn[31:26];
   assign rs      = InsIn[25:21];
   assign rt      = InsIn[20:16];
   assign imm     = InsIn[15:0];
   assign InReady = !OutValid || OutReady;
   assign capture = InValid && InReady;

   // Register file write port; index 0 is never written so it reads back as zero.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (WE && (WAddr != '0)) begin
         regs[WAddr] <= WData;
      end
   end

   // Operand read; with the bypass build a same-cycle write-back is forwarded.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      ext = extend_imm(opcode, imm);
      if (rs == '0) begin
         rd1 = '0;
`ifdef ID_WB_BYPASS_EN
      end else if (WE && (WAddr == rs)) begin
         rd1 = WData;
`endif
      end else begin
         rd1 = regs[rs];
      end
      // REGIMM passes the rt selector itself so EX can tell BGEZ from BLTZ.
      if (opcode == OP_REGIMM) begin
         rd2 = {{(DATA_W-AW){1'b0}}, rt};
      end else if (rt == '0) begin
         rd2 = '0;
`ifdef ID_WB_BYPASS_EN
      end else if (WE && (WAddr == rt)) begin
         rd2 = WData;
`endif
      end else begin
         rd2 = regs[rt];
      end
   end

   // Single-entry pipeline register; holds its contents while EX stalls.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OutValid <= 1'b0;
         Ins      <= 32'h0000_0000;
         nextPC   <= 32'h0000_0000;
         Rdata1   <= '0;
         Rdata2   <= '0;
         Ed32     <= '0;
      end else if (capture) begin
         OutValid <= 1'b1;
         Ins      <= InsIn;
         nextPC   <= nextPCIn;
         Rdata1   <= rd1;
         Rdata2   <= rd2;
         Ed32     <= ext;
      end else if (OutReady) begin
         OutValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, stall/reset sequences and a
// randomized phase scored against a behavioural model (honours ID_WB_BYPASS_EN).
module tb_id_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] InsIn;
   logic [31:0] nextPCIn;
   logic        InValid;
   logic        InReady;
   logic        WE;
   logic [4:0]  WAddr;
   logic [31:0] WData;
   logic [31:0] Ins;
   logic [31:0] nextPC;
   logic [31:0] Rdata1;
   logic [31:0] Rdata2;
   logic [31:0] Ed32;
   logic        OutValid;
   logic        OutReady;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ed;
   } vec_t;

   vec_t vecs [10];

   // behavioural model state
   logic [31:0] m_regs [32];
   logic [31:0] view [32];
   logic        m_valid;
   logic [31:0] m_ins, m_pc, m_rd1, m_rd2, m_ed;
   logic [31:0] pc_next, cons_pc;
   logic [5:0]  r_op;
   logic [4:0]  r_rs, r_rt;
   logic [15:0] r_imm;
   logic        cap;
   logic [31:0] byp_exp;

   always #5 CLK = ~CLK;

   id_stage dut (
      .CLK(CLK), .RST(RST), .InsIn(InsIn), .nextPCIn(nextPCIn), .InValid(InValid),
      .InReady(InReady), .WE(WE), .WAddr(WAddr), .WData(WData), .Ins(Ins), .nextPC(nextPC),
      .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32), .OutValid(OutValid), .OutReady(OutReady)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_out(input string name, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] ed);
      chk({name, ".valid"}, {31'd0, OutValid}, 32'd1);
      chk({name, ".ins"}, Ins, ins);
      chk({name, ".pc"}, nextPC, pc);
      chk({name, ".rd1"}, Rdata1, rd1);
      chk({name, ".rd2"}, Rdata2, rd2);
      chk({name, ".ed"}, Ed32, ed);
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      WE = 1'b1; WAddr = a; WData = d; InValid = 1'b0; OutReady = 1'b1;
      tick();
      WE = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      InsIn = ins; nextPCIn = pc; InValid = 1'b1; OutReady = 1'b1;
      tick();
      InValid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'h20A6FFFC, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFC}; // ADDI rs5
      vecs[1] = '{32'h34058000, 32'h0000_0000, 32'h0000_1234, 32'h0000_8000}; // ORI
      vecs[2] = '{32'h3C01ABCD, 32'h0000_0000, 32'h0000_0055, 32'hABCD_0000}; // LUI
      vecs[3] = '{32'h20000001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001}; // rs=0 after write to r0
      vecs[4] = '{32'h04A10010, 32'h0000_1234, 32'h0000_0001, 32'h0000_0010}; // BGEZ
      vecs[5] = '{32'h04A0FFF0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFF0}; // BLTZ
      vecs[6] = '{32'h3025FFFF, 32'h0000_0055, 32'h0000_1234, 32'h0000_FFFF}; // ANDI
      vecs[7] = '{32'h38A18001, 32'h0000_1234, 32'h0000_0055, 32'h0000_8001}; // XORI
      vecs[8] = '{32'hFC258000, 32'h0000_0055, 32'h0000_1234, 32'hFFFF_8000}; // unknown opcode
      vecs[9] = '{32'h00A11820, 32'h0000_1234, 32'h0000_0055, 32'h0000_1820}; // add $3,$5,$1

      RST = 1'b1; InsIn = '0; nextPCIn = '0; InValid = 1'b0; WE = 1'b0;
      WAddr = '0; WData = '0; OutReady = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      chk("rst.valid", {31'd0, OutValid}, 32'd0);
      chk("rst.ins", Ins, 32'd0);
      chk("rst.pc", nextPC, 32'd0);
      chk("rst.rd1", Rdata1, 32'd0);
      chk("rst.rd2", Rdata2, 32'd0);
      chk("rst.ed", Ed32, 32'd0);
      #1;
      chk("rst.inready", {31'd0, InReady}, 32'd1);

      issue(32'h00221820, 32'h0000_0004);
      check_out("add_empty", 32'h00221820, 32'h0000_0004, 32'd0, 32'd0, 32'h0000_1820);

      write_reg(5'd5, 32'h0000_1234);
      write_reg(5'd1, 32'h0000_0055);
      write_reg(5'd0, 32'hDEAD_BEEF);

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].ins, 32'h100 + 32'(i) * 32'd4);
         check_out($sformatf("vec%0d", i), vecs[i].ins, 32'h100 + 32'(i) * 32'd4,
                   vecs[i].rd1, vecs[i].rd2, vecs[i].ed);
      end

      // stall: hold entry A for three cycles, later write must not leak into it
      OutReady = 1'b1; InValid = 1'b0;
      tick();
      OutReady = 1'b0; InValid = 1'b1; InsIn = 32'h20A6FFFC; nextPCIn = 32'h200;
      #1;
      chk("stall.inready0", {31'd0, InReady}, 32'd1);
      tick();
      InsIn = 32'h3C01ABCD; nextPCIn = 32'h204;
      for (int c = 0; c < 3; c++) begin
         WE = (c == 0); WAddr = 5'd5; WData = 32'h0000_CAFE;
         #1;
         chk($sformatf("stall%0d.inready", c), {31'd0, InReady}, 32'd0);
         tick();
         check_out($sformatf("stall%0d", c), 32'h20A6FFFC, 32'h200, 32'h1234, 32'd0, 32'hFFFF_FFFC);
      end
      WE = 1'b0; OutReady = 1'b1;
      #1;
      chk("unstall.inready", {31'd0, InReady}, 32'd1);
      tick();
      InValid = 1'b0;
      check_out("unstall", 32'h3C01ABCD, 32'h204, 32'd0, 32'h55, 32'hABCD_0000);

      // register 0 is never bypassed
      WE = 1'b1; WAddr = 5'd0; WData = 32'hFFFF_FFFF;
      issue(32'h20000001, 32'h300);
      WE = 1'b0;
      check_out("r0_nobypass", 32'h20000001, 32'h300, 32'd0, 32'd0, 32'd1);

      // same-cycle write and capture on rs/rt = 7
      write_reg(5'd7, 32'h0000_0011);
`ifdef ID_WB_BYPASS_EN
      byp_exp = 32'h0000_0077;
`else
      byp_exp = 32'h0000_0011;
`endif
      WE = 1'b1; WAddr = 5'd7; WData = 32'h0000_0077;
      issue(32'h20E70000, 32'h304);
      WE = 1'b0;
      check_out("bypass", 32'h20E70000, 32'h304, byp_exp, byp_exp, 32'd0);

      // reset while an entry is held; write-back in the reset cycle is dropped
      OutReady = 1'b0; InValid = 1'b1; InsIn = 32'h3C01ABCD;
      WE = 1'b1; WAddr = 5'd9; WData = 32'h0000_0099; RST = 1'b1;
      tick();
      RST = 1'b0; WE = 1'b0; InValid = 1'b0;
      chk("midrst.valid", {31'd0, OutValid}, 32'd0);
      chk("midrst.ins", Ins, 32'd0);
      chk("midrst.rd1", Rdata1, 32'd0);
      issue(32'h20E90000, 32'h400);
      check_out("post_rst", 32'h20E90000, 32'h400, 32'd0, 32'd0, 32'd0);

      // randomized phase against the behavioural model
      RST = 1'b1; InValid = 1'b0; WE = 1'b0; OutReady = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_ins = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_ed = 0;
      pc_next = 32'h1000; cons_pc = 32'h1000;
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 7))
            0: r_op = 6'h00;
            1: r_op = 6'h01;
            2: r_op = 6'h08;
            3: r_op = 6'h0C;
            4: r_op = 6'h0D;
            5: r_op = 6'h0E;
            6: r_op = 6'h0F;
            default: r_op = 6'($urandom_range(0, 63));
         endcase
         r_rs = 5'($urandom_range(0, 7));
         r_rt = 5'($urandom_range(0, 7));
         r_imm = 16'($urandom);
         InsIn = {r_op, r_rs, r_rt, r_imm};
         nextPCIn = pc_next;
         InValid = ($urandom_range(0, 3) != 0);
         OutReady = ($urandom_range(0, 2) != 0);
         WE = ($urandom_range(0, 1) != 0);
         WAddr = 5'($urandom_range(0, 7));
         WData = $urandom;
         #1;
         chk("rnd.inready", {31'd0, InReady}, {31'd0, (!m_valid || OutReady)});
         if (OutValid && OutReady) begin
            chk("rnd.order", nextPC, cons_pc);
            cons_pc = cons_pc + 32'd4;
         end
         cap = InValid && (!m_valid || OutReady);
         if (cap) begin
            view = m_regs;
`ifdef ID_WB_BYPASS_EN
            if (WE && WAddr != 5'd0) view[WAddr] = WData;
`endif
            m_valid = 1'b1;
            m_ins = InsIn;
            m_pc = pc_next;
            m_rd1 = view[r_rs];
            m_rd2 = (r_op == 6'h01) ? 32'(r_rt) : view[r_rt];
            if (r_op == 6'h0C || r_op == 6'h0D || r_op == 6'h0E) m_ed = 32'(r_imm);
            else if (r_op == 6'h0F) m_ed = 32'(r_imm) * 32'd65536;
            else if (r_imm >= 16'h8000) m_ed = 32'(r_imm) - 32'h0001_0000;
            else m_ed = 32'(r_imm);
            pc_next = pc_next + 32'd4;
         end else if (OutReady) begin
            m_valid = 1'b0;
         end
         if (WE && WAddr != 5'd0) m_regs[WAddr] = WData;
         @(posedge CLK);
         #1;
         chk("rnd.valid", {31'd0, OutValid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("rnd.ins", Ins, m_ins);
            chk("rnd.pc", nextPC, m_pc);
            chk("rnd.rd1", Rdata1, m_rd1);
            chk("rnd.rd2", Rdata2, m_rd2);
            chk("rnd.ed", Ed32, m_ed);
         end
      end
      InValid = 1'b0; WE = 1'b0; OutReady = 1'b1;
      #1;
      if (OutValid) begin
         chk("rnd.drain_order", nextPC, cons_pc);
         cons_pc = cons_pc + 32'd4;
      end
      tick();
      chk("rnd.all_consumed", cons_pc, pc_next);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage feeding the EX stage.
- Holds the 32x32 general register file and decodes an incoming instruction into operands. It produces Rdata1 (rs), Rdata2 (rt, or the REGIMM selector) and Ed32 (extended immediate).
- Presents these with nextPC/Ins through a single-entry valid/ready pipeline register.
- Accepts the write-back port from the WB stage.

Parameters:
- DATA_W, 32, register and operand width.
- NREG, 32, number of architectural registers; register 0 is hard-wired to zero.
- AW, 5, register address width (log2 NREG).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- InsIn  input  32  instruction from fetch.
- nextPCIn  input  32  PC+4 from fetch.
- InValid  input  1  InsIn/nextPCIn valid.
- InReady  output  1  stage can accept this cycle.
- WE  input  1  write-back enable.
- WAddr  input  AW  write-back register index.
- WData  input  DATA_W  write-back data.
- Ins  output  32  registered instruction to EX.
- nextPC  output  32  registered PC+4 to EX.
- Rdata1  output  DATA_W  registered rs operand.
- Rdata2  output  DATA_W  registered rt operand or REGIMM selector.
- Ed32  output  DATA_W  registered extended immediate.
- OutValid  output  1  outputs hold a decoded instruction.
- OutReady  input  1  EX consumes this cycle.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - All registers 0, OutValid=0, Ins/nextPC/Rdata1/Rdata2/Ed32 = 0.
  - Reset mid-handshake discards the held entry; no write-back occurs in the reset cycle.
- Handshake:
  - InReady = !OutValid || OutReady (combinational).
  - Capture when InValid && InReady.
  - OutValid next = capture ? 1 : (OutReady ? 0 : OutValid).
  - Outputs hold stable while OutValid && !OutReady.
  - Latency 1 cycle. Full throughput when OutReady is held high.
- Field decode: opcode=Ins[31:26], rs=[25:21], rt=[20:16], imm=[15:0].
- Rdata1 = reg[rs].
- Rdata2:
  - For opcode 0x01 (REGIMM): Rdata2 = zero-extended rt field, so EX sees 1 for BGEZ and 0 for BLTZ.
  - Otherwise Rdata2 = reg[rt].
- Ed32:
  - Opcodes 0x0C/0x0D/0x0E (ANDI/ORI/XORI): zero-extend imm.
  - Opcode 0x0F (LUI): {imm,16'h0}.
  - All others: sign-extend imm[15].
- Register file write:
  - On edge with WE=1 and WAddr!=0: reg[WAddr] <= WData.
  - WAddr=0 writes are ignored; reads of register 0 always return 0.
  - Write-back proceeds regardless of handshake state.
- Read timing: operands are sampled in the capture cycle only. A write in a later cycle does not update an already-held entry.
- Same-cycle write and capture reading the same index: see Optional Feature.
- Invalid or unknown opcodes decode normally; no trap.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: in a capture cycle with WE=1, WAddr!=0, and WAddr equal to rs (or to rt for non-REGIMM), the captured operand is WData (write-through).
- Undefined: the captured operand is the pre-write register value. Software/hazard logic must insert one bubble.
- Register 0 is never bypassed in either build.

Test Plan:
- Reset, then read all registers -> OutValid=0, all outputs 0. Instruction "add $3,$1,$2" with regs empty -> Rdata1=0, Rdata2=0.
- WE=1, WAddr=5, WData=0x1234. Next cycle capture of ADDI rs=5, imm=0xFFFC -> Rdata1=0x1234, Ed32=0xFFFFFFFC. ORI imm=0x8000 -> Ed32=0x00008000. LUI imm=0xABCD -> Ed32=0xABCD0000.
- Write WAddr=0, WData=0xDEADBEEF, then read rs=0 -> Rdata1=0.
- REGIMM instruction, rt=1, reg[1]=0x55 -> Rdata2=1. Same instruction with rt=0 -> Rdata2=0.
- OutReady=0 for 3 cycles with InValid=1 -> InReady=0 after the first capture, outputs unchanged. Raise OutReady -> next instruction captured; no loss or duplication over a 10-instruction stream.
- Same-cycle WE=1, WAddr=7, WData=0x77 and capture with rs=7 (old reg[7]=0x11) -> Rdata1=0x77 with ID_WB_BYPASS_EN, 0x11 without. Assert RST while OutValid=1 -> next cycle OutValid=0 and reg[7]=0.
